// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO blocks and the read-side arbiter.
package fifo_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int DSIZE_DEFAULT    = 8;
   localparam int ADDRSIZE_DEFAULT = 4;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping modulo N.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [N-1:0] rotated;
   logic [W-1:0] offset;

   function automatic int wrap_idx(input int value);
      return (value >= N) ? value - N : value;
   endfunction

   // Rotate so the pointer sits at bit 0, priority-encode, then rotate the result back.
   always_comb begin
      rotated = '0;
      offset  = '0;
      for (int i = 0; i < N; i++) begin
         rotated[i] = req[wrap_idx(int'(ptr) + i)];
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            offset = W'(i);
         end
      end
      found = |req;
      idx   = W'(wrap_idx(int'(ptr) + int'(offset)));
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read-side scheduler sharing one valid/ready consumer among
// NUM_SRC FIFO read ports, popping up to BURST words per grant.
module fifo_rd_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int DSIZE   = fifo_pkg::DSIZE_DEFAULT,
   parameter int BURST   = 4,
   localparam int SRC_W  = fifo_pkg::clog2(NUM_SRC)
) (
   input  logic                     rclk,
   input  logic                     rrst,
   input  logic [NUM_SRC-1:0]       rempty,
   input  logic [NUM_SRC*DSIZE-1:0] rdata,
   output logic [NUM_SRC-1:0]       rinc,
   output logic                     out_valid,
   output logic [DSIZE-1:0]         out_data,
   output logic [SRC_W-1:0]         out_src,
   input  logic                     out_ready,
   output logic                     busy
);

   import fifo_pkg::*;

   localparam int                 CNT_W    = clog2(BURST + 1);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BURST - 1);
   localparam logic [SRC_W-1:0]   LAST_SRC = SRC_W'(NUM_SRC - 1);

   arb_state_e        state_q, state_d;
   logic [SRC_W-1:0]  grant_q, grant_d;
   logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [DSIZE-1:0]  out_data_q, out_data_d;
   logic [SRC_W-1:0]  out_src_q, out_src_d;

   logic              pick_found;
   logic [SRC_W-1:0]  pick_idx;
   logic [SRC_W-1:0]  next_src;
   logic [DSIZE-1:0]  sel_data;
   logic              grant_empty;
   logic              pop;

   rr_pick #(
      .N (NUM_SRC),
      .W (SRC_W)
   ) u_pick (
      .req   (~rempty),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      sel_data    = '0;
      grant_empty = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_q == SRC_W'(i)) begin
            sel_data    = rdata[i*DSIZE +: DSIZE];
            grant_empty = rempty[i];
         end
      end
   end

   // A pop needs the granted FIFO non-empty and room in the single-entry output stage.
   assign pop      = (state_q == fifo_pkg::BURST) && !grant_empty && (!out_valid_q || out_ready);
   assign next_src = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;

   always_comb begin
      rinc = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         rinc[i] = pop && (grant_q == SRC_W'(i));
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         fifo_pkg::IDLE: begin
            if (pick_found) begin
               grant_d     = pick_idx;
               burst_cnt_d = '0;
               state_d     = fifo_pkg::BURST;
            end
         end
         fifo_pkg::BURST: begin
            // The burst-count exit is checked first; a drain in the same cycle ends identically.
            if (pop) begin
               if (burst_cnt_q == LAST_CNT) begin
                  burst_cnt_d = '0;
                  rr_ptr_d    = next_src;
                  state_d     = fifo_pkg::IDLE;
               end else begin
                  burst_cnt_d = burst_cnt_q + 1'b1;
               end
            end else if (grant_empty) begin
               rr_ptr_d = next_src;
               state_d  = fifo_pkg::IDLE;
            end
         end
         default: state_d = fifo_pkg::IDLE;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (pop) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_src_d   = grant_q;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state_q     <= fifo_pkg::IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign busy      = (state_q == fifo_pkg::BURST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: directed vectors, corner sequences
// and a randomized run against per-source FIFO queues and a scoreboard.
module tb_fifo_rd_arbiter;

   localparam int NUM_SRC    = 4;
   localparam int DSIZE      = 8;
   localparam int BURST      = 4;
   localparam int FAIR_BOUND = (NUM_SRC - 1) * BURST;

   logic                     rclk = 1'b0;
   logic                     rrst;
   logic [NUM_SRC-1:0]       rempty;
   logic [NUM_SRC*DSIZE-1:0] rdata;
   logic [NUM_SRC-1:0]       rinc;
   logic                     out_valid;
   logic [DSIZE-1:0]         out_data;
   logic [1:0]               out_src;
   logic                     out_ready;
   logic                     busy;

   int total;
   int bad;
   bit sb_en;

   logic [7:0] fifo_q [NUM_SRC][$];
   logic [7:0] exp_q  [NUM_SRC][$];
   int         wait_cnt [NUM_SRC];

   typedef struct {
      logic       ready;
      logic       valid;
      logic [1:0] src;
      logic [7:0] data;
      logic [3:0] rinc;
      logic       busy;
   } vec_t;

   vec_t vecs [18];

   fifo_rd_arbiter #(
      .NUM_SRC (NUM_SRC),
      .DSIZE   (DSIZE),
      .BURST   (BURST)
   ) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 rclk = ~rclk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
      end
   endtask

   // The FIFO read side presents the head word and an empty flag from each queue.
   task automatic refreshInputs();
      for (int i = 0; i < NUM_SRC; i++) begin
         rempty[i] = (fifo_q[i].size() == 0);
         rdata[i*DSIZE +: DSIZE] = (fifo_q[i].size() == 0) ? 8'h00 : fifo_q[i][0];
      end
   endtask

   task automatic pushWord(input int src, input logic [7:0] data);
      fifo_q[src].push_back(data);
      exp_q[src].push_back(data);
   endtask

   // One clock cycle: sample rinc and the handshake before the edge, then retire popped words.
   task automatic applyStimulus(input logic ready);
      logic [3:0] cap_rinc;
      logic       cap_acc;
      logic [1:0] cap_src;
      logic [7:0] cap_data;
      logic [7:0] want;
      int         worst;
      out_ready = ready;
      #1;
      cap_rinc = rinc;
      cap_acc  = out_valid && out_ready;
      cap_src  = out_src;
      cap_data = out_data;
      checkOutput("rinc_onehot", 32'($onehot0(cap_rinc)), 1);
      checkOutput("rinc_on_empty", 32'(cap_rinc & rempty), 0);
      if (rrst) checkOutput("rinc_in_reset", 32'(cap_rinc), 0);
      worst = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (rempty[i] || cap_rinc[i]) wait_cnt[i] = 0;
         else if (cap_rinc != 0) wait_cnt[i]++;
         if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      checkOutput("fairness_bound", 32'(worst <= FAIR_BOUND), 1);
      @(posedge rclk);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (cap_rinc[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
      end
      if (sb_en && cap_acc && !rrst) begin
         checkOutput("sb_word_expected", 32'(exp_q[cap_src].size() != 0), 1);
         if (exp_q[cap_src].size() != 0) begin
            want = exp_q[cap_src].pop_front();
            checkOutput($sformatf("sb_data_src%0d", cap_src), 32'(cap_data), 32'(want));
         end
      end
      refreshInputs();
      #1;
   endtask

   task automatic resetDut();
      rrst = 1'b1;
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
         fifo_q[i].delete();
         exp_q[i].delete();
         wait_cnt[i] = 0;
      end
      refreshInputs();
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      rrst = 1'b0;
      #1;
   endtask

   task automatic setVec(input int r, input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] ri, input logic b);
      vecs[r] = '{1'b1, v, s, d, ri, b};
   endtask

   function automatic bit allDrained();
      for (int i = 0; i < NUM_SRC; i++) begin
         if (fifo_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   initial begin
      total     = 0;
      bad       = 0;
      sb_en     = 1'b0;
      rrst      = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) wait_cnt[i] = 0;

      // Two FIFOs of six words each: cap at four, one bubble per grant, drain exits.
      setVec(0,  0, 0, 8'h00, 4'b0001, 1);
      setVec(1,  1, 0, 8'h00, 4'b0001, 1);
      setVec(2,  1, 0, 8'h01, 4'b0001, 1);
      setVec(3,  1, 0, 8'h02, 4'b0001, 1);
      setVec(4,  1, 0, 8'h03, 4'b0000, 0);
      setVec(5,  0, 0, 8'h00, 4'b0010, 1);
      setVec(6,  1, 1, 8'h10, 4'b0010, 1);
      setVec(7,  1, 1, 8'h11, 4'b0010, 1);
      setVec(8,  1, 1, 8'h12, 4'b0010, 1);
      setVec(9,  1, 1, 8'h13, 4'b0000, 0);
      setVec(10, 0, 0, 8'h00, 4'b0001, 1);
      setVec(11, 1, 0, 8'h04, 4'b0001, 1);
      setVec(12, 1, 0, 8'h05, 4'b0000, 1);
      setVec(13, 0, 0, 8'h00, 4'b0000, 0);
      setVec(14, 0, 0, 8'h00, 4'b0010, 1);
      setVec(15, 1, 1, 8'h14, 4'b0010, 1);
      setVec(16, 1, 1, 8'h15, 4'b0000, 1);
      setVec(17, 0, 0, 8'h00, 4'b0000, 0);

      $display("[TB] reset with all FIFOs non-empty");
      for (int i = 0; i < NUM_SRC; i++) fifo_q[i].push_back(8'(8'h50 + i));
      refreshInputs();
      #1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1);
         checkOutput("reset_rinc", 32'(rinc), 0);
         checkOutput("reset_valid", 32'(out_valid), 0);
      end
      checkOutput("reset_data", 32'(out_data), 0);
      checkOutput("reset_src", 32'(out_src), 0);
      checkOutput("reset_busy", 32'(busy), 0);
      rrst = 1'b0;
      #1;
      checkOutput("release_rinc", 32'(rinc), 0);
      applyStimulus(1'b1);
      checkOutput("first_edge_valid", 32'(out_valid), 0);
      checkOutput("first_grant_rinc", 32'(rinc), 32'h1);
      applyStimulus(1'b1);
      checkOutput("first_pop_src", 32'(out_src), 0);
      checkOutput("first_pop_data", 32'(out_data), 32'h50);

      $display("[TB] burst cap vectors");
      resetDut();
      for (int k = 0; k < 6; k++) begin
         pushWord(0, 8'(k));
         pushWord(1, 8'(8'h10 + k));
      end
      refreshInputs();
      for (int r = 0; r < 18; r++) begin
         applyStimulus(vecs[r].ready);
         checkOutput($sformatf("vec%0d_valid", r), 32'(out_valid), 32'(vecs[r].valid));
         checkOutput($sformatf("vec%0d_rinc", r), 32'(rinc), 32'(vecs[r].rinc));
         checkOutput($sformatf("vec%0d_busy", r), 32'(busy), 32'(vecs[r].busy));
         if (vecs[r].valid) begin
            checkOutput($sformatf("vec%0d_src", r), 32'(out_src), 32'(vecs[r].src));
            checkOutput($sformatf("vec%0d_data", r), 32'(out_data), 32'(vecs[r].data));
         end
      end

      $display("[TB] early drain then wrap-around");
      resetDut();
      pushWord(2, 8'hA1);
      pushWord(2, 8'hA2);
      refreshInputs();
      applyStimulus(1'b1);
      checkOutput("drain_grant_busy", 32'(busy), 1);
      applyStimulus(1'b1);
      checkOutput("drain_w0_src", 32'(out_src), 2);
      checkOutput("drain_w0_data", 32'(out_data), 32'hA1);
      applyStimulus(1'b1);
      checkOutput("drain_w1_data", 32'(out_data), 32'hA2);
      applyStimulus(1'b1);
      checkOutput("drain_idle_busy", 32'(busy), 0);
      checkOutput("drain_idle_valid", 32'(out_valid), 0);
      pushWord(3, 8'h31);
      pushWord(3, 8'h32);
      pushWord(0, 8'h01);
      pushWord(0, 8'h02);
      refreshInputs();
      applyStimulus(1'b1);
      checkOutput("wrap_first_rinc", 32'(rinc), 32'h8);
      applyStimulus(1'b1);
      checkOutput("wrap_w0_src", 32'(out_src), 3);
      checkOutput("wrap_w0_data", 32'(out_data), 32'h31);
      applyStimulus(1'b1);
      checkOutput("wrap_w1_data", 32'(out_data), 32'h32);
      applyStimulus(1'b1);
      checkOutput("wrap_exit_busy", 32'(busy), 0);
      applyStimulus(1'b1);
      checkOutput("wrap_second_rinc", 32'(rinc), 32'h1);
      applyStimulus(1'b1);
      checkOutput("wrap_w2_src", 32'(out_src), 0);
      checkOutput("wrap_w2_data", 32'(out_data), 32'h01);
      applyStimulus(1'b1);
      checkOutput("wrap_w3_data", 32'(out_data), 32'h02);

      $display("[TB] back-pressure mid-burst");
      resetDut();
      for (int k = 1; k <= 6; k++) pushWord(1, 8'(8'h40 + k));
      refreshInputs();
      applyStimulus(1'b1);
      checkOutput("bp_grant_rinc", 32'(rinc), 32'h2);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("bp_pre_data", 32'(out_data), 32'h42);
      out_ready = 1'b0;
      #1;
      checkOutput("bp_stall_rinc", 32'(rinc), 0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0);
         checkOutput("bp_hold_valid", 32'(out_valid), 1);
         checkOutput("bp_hold_data", 32'(out_data), 32'h42);
         checkOutput("bp_hold_rinc", 32'(rinc), 0);
         checkOutput("bp_hold_busy", 32'(busy), 1);
      end
      checkOutput("bp_fifo_level", fifo_q[1].size(), 4);
      applyStimulus(1'b1);
      checkOutput("bp_resume_data", 32'(out_data), 32'h43);
      checkOutput("bp_resume_busy", 32'(busy), 1);
      applyStimulus(1'b1);
      checkOutput("bp_last_data", 32'(out_data), 32'h44);
      checkOutput("bp_cap_exit", 32'(busy), 0);
      applyStimulus(1'b1);
      checkOutput("bp_bubble_valid", 32'(out_valid), 0);
      checkOutput("bp_regrant_rinc", 32'(rinc), 32'h2);
      applyStimulus(1'b1);
      checkOutput("bp_next_data", 32'(out_data), 32'h45);

      $display("[TB] reset in the middle of a burst");
      resetDut();
      pushWord(1, 8'h61);
      for (int k = 1; k <= 4; k++) pushWord(3, 8'(8'h70 + k));
      refreshInputs();
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("mr_w0_src", 32'(out_src), 1);
      applyStimulus(1'b1);
      checkOutput("mr_drain_busy", 32'(busy), 0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("mr_w1_data", 32'(out_data), 32'h71);
      applyStimulus(1'b1);
      checkOutput("mr_w2_data", 32'(out_data), 32'h72);
      rrst = 1'b1;
      #1;
      checkOutput("mr_clear_valid", 32'(out_valid), 0);
      checkOutput("mr_clear_data", 32'(out_data), 0);
      checkOutput("mr_clear_src", 32'(out_src), 0);
      checkOutput("mr_clear_rinc", 32'(rinc), 0);
      checkOutput("mr_clear_busy", 32'(busy), 0);
      pushWord(0, 8'h81);
      refreshInputs();
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      rrst = 1'b0;
      #1;
      checkOutput("mr_release_rinc", 32'(rinc), 0);
      applyStimulus(1'b1);
      checkOutput("mr_restart_rinc", 32'(rinc), 32'h1);
      applyStimulus(1'b1);
      checkOutput("mr_restart_src", 32'(out_src), 0);
      checkOutput("mr_restart_data", 32'(out_data), 32'h81);

      $display("[TB] randomized traffic with scoreboard");
      resetDut();
      sb_en = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if ($urandom_range(0, 99) < ((c < 1000) ? 10 : 35)) pushWord(i, 8'($urandom_range(0, 255)));
         end
         refreshInputs();
         applyStimulus($urandom_range(0, 3) != 0);
      end
      for (int k = 0; k < 3000 && !allDrained(); k++) applyStimulus(1'b1);
      checkOutput("random_drained", 32'(allDrained()), 1);
      checkOutput("random_final_valid", 32'(out_valid), 0);
      sb_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
